// File: rtl/spi_leader_ctrl.sv
// -----------------------------------------------------------------------------
// spi_leader_ctrl
// Transfer sequencer for an SPI leader. Generates chip select, the parallel
// load pulse and the per-edge shift/sample strobes for the leader and follower
// shift registers. SCLK is generated elsewhere; this block only sees one-cycle
// rising/falling edge strobes from the edge detectors.
//
// Parameters
//   NBITS      bits per transfer (2..15)
//   SETUP_CYC  clk cycles from cs falling to the first counted SCLK edge
//   HOLD_CYC   clk cycles from the last SCLK edge to cs rising
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   start      transfer request, only honoured in IDLE
//   abort      cancel the transfer in progress
//   mode[1:0]  {CPOL, CPHA}, latched when start is accepted
//   sclk_pe    SCLK rising-edge strobe
//   sclk_ne    SCLK falling-edge strobe
//   cs         chip select, active low
//   cpol       latched CPOL for the clock generator
//   load       one-cycle parallel-load pulse
//   shift_en   one-cycle shift strobe
//   sample_en  one-cycle sample strobe
//   busy       high whenever the FSM is not idle
//   done       one-cycle completion pulse
//   bit_cnt    sample strobes issued in the current transfer
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for start; cs high, cpol keeps last latched value
// LOAD  | one cycle, load pulse to both shift registers, cs still high
// SETUP | cs low, SETUP_CYC cycles, SCLK edges ignored
// XFER  | counting SCLK edges 0..2*NBITS-1, issuing shift/sample strobes
// HOLD  | cs low for HOLD_CYC cycles after the last edge, SCLK edges ignored
// -----------------------------------------------------------------------------
module spi_leader_ctrl #(
   parameter int NBITS     = 8,
   parameter int SETUP_CYC = 2,
   parameter int HOLD_CYC  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [1:0] mode,
   input  logic       sclk_pe,
   input  logic       sclk_ne,
   output logic       cs,
   output logic       cpol,
   output logic       load,
   output logic       shift_en,
   output logic       sample_en,
   output logic       busy,
   output logic       done,
   output logic [3:0] bit_cnt
);

   localparam int TMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
   localparam int EW   = $clog2(2 * NBITS);

   localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
   localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);
   localparam logic [EW-1:0] LAST_E   = EW'(2 * NBITS - 1);
   localparam logic [3:0]    CNT_MAX  = 4'(NBITS);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETUP,
      XFER,
      HOLD
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [EW-1:0] e_q, e_d;
   logic          cpha_q, cpha_d;
   logic          cpol_d;
   logic          cs_d, load_d, shift_d, sample_d, busy_d, done_d;
   logic [3:0]    bit_cnt_d;

   logic          lead_edge, trail_edge, odd_e, edge_hit;

   // Leading edge leaves the idle SCLK level: rising for CPOL=0, falling for CPOL=1.
   assign lead_edge  = cpol ? sclk_ne : sclk_pe;
   assign trail_edge = cpol ? sclk_pe : sclk_ne;
   assign odd_e      = e_q[0];
   // Only the edge type expected at the current count advances the counter.
   assign edge_hit   = odd_e ? trail_edge : lead_edge;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         tmr_q     <= '0;
         e_q       <= '0;
         cpha_q    <= 1'b0;
         cpol      <= 1'b0;
         cs        <= 1'b1;
         load      <= 1'b0;
         shift_en  <= 1'b0;
         sample_en <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bit_cnt   <= 4'd0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         e_q       <= e_d;
         cpha_q    <= cpha_d;
         cpol      <= cpol_d;
         cs        <= cs_d;
         load      <= load_d;
         shift_en  <= shift_d;
         sample_en <= sample_d;
         busy      <= busy_d;
         done      <= done_d;
         bit_cnt   <= bit_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      e_d       = e_q;
      cpha_d    = cpha_q;
      cpol_d    = cpol;
      cs_d      = cs;
      load_d    = 1'b0;
      shift_d   = 1'b0;
      sample_d  = 1'b0;
      done_d    = 1'b0;
      bit_cnt_d = bit_cnt;

      case (state_q)
         IDLE: begin
            cs_d = 1'b1;
            if (start) begin
               state_d   = LOAD;
               cpol_d    = mode[1];
               cpha_d    = mode[0];
               bit_cnt_d = 4'd0;
               e_d       = '0;
               load_d    = 1'b1;
            end
         end
         LOAD: begin
            state_d = SETUP;
            cs_d    = 1'b0;
            tmr_d   = SETUP_LD;
         end
         SETUP: begin
            if (tmr_q == '0) begin
               state_d = XFER;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         XFER: begin
            if (edge_hit) begin
               // CPHA=0 samples on even (leading) edges, CPHA=1 on odd (trailing).
               if (odd_e == cpha_q) begin
                  sample_d = 1'b1;
                  if (bit_cnt < CNT_MAX) begin
                     bit_cnt_d = bit_cnt + 4'd1;
                  end
               end else if ((e_q != '0) && (e_q != LAST_E)) begin
                  // No shift before the first sample or after the last one.
                  shift_d = 1'b1;
               end
               if (e_q == LAST_E) begin
                  state_d = HOLD;
                  tmr_d   = HOLD_LD;
               end else begin
                  e_d = e_q + EW'(1);
               end
            end
         end
         HOLD: begin
            if (tmr_q == '0) begin
               state_d = IDLE;
               cs_d    = 1'b1;
               done_d  = 1'b1;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cs_d    = 1'b1;
         end
      endcase

      // Abort wins over any edge or timer event; bit_cnt keeps its last value.
      if (abort && (state_q != IDLE)) begin
         state_d   = IDLE;
         cs_d      = 1'b1;
         load_d    = 1'b0;
         shift_d   = 1'b0;
         sample_d  = 1'b0;
         done_d    = 1'b0;
         tmr_d     = tmr_q;
         e_d       = e_q;
         bit_cnt_d = bit_cnt;
      end

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_spi_leader_ctrl.sv
module tb_spi_leader_ctrl;

   localparam int N  = 8;
   localparam int NI = 3;
   localparam int L  = 128;

   function automatic int su_of(input int g);
      case (g)
         1:       su_of = 1;
         2:       su_of = 4;
         default: su_of = 2;
      endcase
   endfunction

   function automatic int ho_of(input int g);
      case (g)
         1:       ho_of = 4;
         2:       ho_of = 1;
         default: ho_of = 2;
      endcase
   endfunction

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NI-1:0]         start_i, abort_i, pe_i, ne_i;
   logic [NI-1:0][1:0]    mode_i;
   logic [NI-1:0]         cs_o, cpol_o, load_o, shift_o, sample_o, busy_o, done_o;
   logic [NI-1:0][3:0]    cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      spi_leader_ctrl #(
         .NBITS    (N),
         .SETUP_CYC(su_of(g)),
         .HOLD_CYC (ho_of(g))
      ) dut (
         .clk      (clk),
         .rst      (rst),
         .start    (start_i[g]),
         .abort    (abort_i[g]),
         .mode     (mode_i[g]),
         .sclk_pe  (pe_i[g]),
         .sclk_ne  (ne_i[g]),
         .cs       (cs_o[g]),
         .cpol     (cpol_o[g]),
         .load     (load_o[g]),
         .shift_en (shift_o[g]),
         .sample_en(sample_o[g]),
         .busy     (busy_o[g]),
         .done     (done_o[g]),
         .bit_cnt  (cnt_o[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input int d, input string why);
      chk($sformatf("%s d%0d cs", why, d), 32'(cs_o[d]), 1);
      chk($sformatf("%s d%0d cpol", why, d), 32'(cpol_o[d]), 0);
      chk($sformatf("%s d%0d load", why, d), 32'(load_o[d]), 0);
      chk($sformatf("%s d%0d shift", why, d), 32'(shift_o[d]), 0);
      chk($sformatf("%s d%0d sample", why, d), 32'(sample_o[d]), 0);
      chk($sformatf("%s d%0d busy", why, d), 32'(busy_o[d]), 0);
      chk($sformatf("%s d%0d done", why, d), 32'(done_o[d]), 0);
      chk($sformatf("%s d%0d bit_cnt", why, d), 32'(cnt_o[d]), 0);
   endtask

   // One transfer on instance d. Index k = edge number counted from the edge
   // that accepts start; inputs for edge k are driven before it, outputs
   // for k are checked just after it.
   // ab_sel: -1 none, 0..2N-1 abort together with that SCLK edge,
   //         100 abort during SETUP, 200 abort during HOLD.
   // rst_e : -1 none, else pulse reset in the cycle after that SCLK edge.
   task automatic run_xfer(input int d, input logic [1:0] md, input logic [N-1:0] ldat,
                           input logic [N-1:0] fdat, input int ab_sel, input int rst_e,
                           input bit noise);
      int         su, ho, kl, ka, kend, kmax, kk, cnt;
      int         t[2*N];
      bit         st[L], ab[L], pe[L], ne[L], es[L], eh[L];
      logic [1:0] mo[L];
      logic [N-1:0] lsr, fsr;
      logic       lcap, fcap;
      bit         is_lead, smp;

      su = su_of(d);
      ho = ho_of(d);
      for (int k = 0; k < L; k++) begin
         st[k] = 0; ab[k] = 0; pe[k] = 0; ne[k] = 0; es[k] = 0; eh[k] = 0; mo[k] = md;
      end

      kk = su + 2 + int'($urandom_range(0, 2));
      for (int e = 0; e < 2*N; e++) begin
         t[e] = kk;
         kk += int'($urandom_range(1, 3));
      end
      kl = t[2*N-1];

      if (ab_sel >= 0 && ab_sel < 2*N) ka = t[ab_sel];
      else if (ab_sel == 100)          ka = 2;
      else if (ab_sel == 200)          ka = kl + 1;
      else                             ka = -1;
      kend = (ka >= 0) ? ka : kl + ho;
      kmax = (rst_e >= 0) ? t[rst_e] : kend + 3;

      st[0] = 1;
      if (noise) begin
         ab[0] = 1'($urandom_range(0, 1));
         for (int k = 1; k <= kend; k++) begin
            st[k] = 1'($urandom_range(0, 1));
            mo[k] = 2'($urandom_range(0, 3));
         end
      end
      for (int k = 1; k <= su + 1; k++) begin
         if (ka < 0 || k <= ka) begin
            pe[k] = 1'($urandom_range(0, 1));
            ne[k] = 1'($urandom_range(0, 1));
         end
      end
      for (int k = kl + 1; k <= kl + ho; k++) begin
         if (ka < 0 || k <= ka) begin
            pe[k] = 1'($urandom_range(0, 1));
            ne[k] = 1'($urandom_range(0, 1));
         end
      end
      for (int e = 0; e < 2*N; e++) begin
         is_lead = (e % 2 == 0);
         if (ka < 0 || t[e] <= ka) begin
            if (is_lead ^ md[1]) pe[t[e]] = 1;
            else                 ne[t[e]] = 1;
         end
         // CPHA=0: sample on leading, shift on trailing except the last.
         // CPHA=1: shift on leading except the first, sample on trailing.
         if (ka < 0 || t[e] < ka) begin
            smp = md[0] ? !is_lead : is_lead;
            if (smp)                          es[t[e]] = 1;
            else if (e != 0 && e != 2*N - 1)  eh[t[e]] = 1;
         end
      end
      if (ka >= 0) ab[ka] = 1;

      cnt = 0; lsr = '0; fsr = '0; lcap = 0; fcap = 0;
      for (int k = 0; k <= kmax; k++) begin
         start_i[d] = st[k];
         abort_i[d] = ab[k];
         pe_i[d]    = pe[k];
         ne_i[d]    = ne[k];
         mode_i[d]  = mo[k];
         @(posedge clk);
         #1;
         if (es[k]) cnt++;
         chk($sformatf("d%0d m%0d k%0d load", d, md, k), 32'(load_o[d]), (k == 0) ? 1 : 0);
         chk($sformatf("d%0d m%0d k%0d cs", d, md, k), 32'(cs_o[d]), (k >= 1 && k < kend) ? 0 : 1);
         chk($sformatf("d%0d m%0d k%0d busy", d, md, k), 32'(busy_o[d]), (k < kend) ? 1 : 0);
         chk($sformatf("d%0d m%0d k%0d done", d, md, k), 32'(done_o[d]), (ka < 0 && k == kend) ? 1 : 0);
         chk($sformatf("d%0d m%0d k%0d cpol", d, md, k), 32'(cpol_o[d]), 32'(md[1]));
         chk($sformatf("d%0d m%0d k%0d sample", d, md, k), 32'(sample_o[d]), 32'(es[k]));
         chk($sformatf("d%0d m%0d k%0d shift", d, md, k), 32'(shift_o[d]), 32'(eh[k]));
         chk($sformatf("d%0d m%0d k%0d bit_cnt", d, md, k), 32'(cnt_o[d]), cnt);
         if (load_o[d]) begin
            lsr = ldat; fsr = fdat;
         end else if (sample_o[d]) begin
            lcap = fsr[N-1]; fcap = lsr[N-1];
         end else if (shift_o[d]) begin
            lsr = {lsr[N-2:0], lcap};
            fsr = {fsr[N-2:0], fcap};
         end
         if (k < kmax || rst_e < 0) @(negedge clk);
      end
      start_i[d] = 0; abort_i[d] = 0; pe_i[d] = 0; ne_i[d] = 0;

      if (rst_e >= 0) begin
         #2;
         rst = 1'b0;
         #1;
         chk_reset(d, "async rst");
         @(negedge clk);
         rst = 1'b1;
         for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post rst d%0d j%0d done", d, j), 32'(done_o[d]), 0);
            chk($sformatf("post rst d%0d j%0d busy", d, j), 32'(busy_o[d]), 0);
            chk($sformatf("post rst d%0d j%0d cs", d, j), 32'(cs_o[d]), 1);
            @(negedge clk);
         end
      end else if (ka < 0) begin
         chk($sformatf("d%0d m%0d leader rx", d, md), 32'({lsr[N-2:0], lcap}), 32'(fdat));
         chk($sformatf("d%0d m%0d follower rx", d, md), 32'({fsr[N-2:0], fcap}), 32'(ldat));
      end
   endtask

   initial begin
      int dd, sel;
      rst     = 1'b0;
      start_i = '0; abort_i = '0; pe_i = '0; ne_i = '0; mode_i = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < NI; d++) chk_reset(d, "reset");
      rst = 1'b1;
      @(negedge clk);

      run_xfer(0, 2'd0, 8'hA5, 8'h3C, -1, -1, 0);
      for (int m = 0; m < 4; m++) run_xfer(0, 2'(m), 8'hA5, 8'h3C, -1, -1, 0);

      // Abort in mode 2 on the edge after bit_cnt reaches 3, then a clean transfer.
      run_xfer(0, 2'd2, 8'($urandom), 8'($urandom), 5, -1, 0);
      run_xfer(0, 2'd2, 8'hA5, 8'h3C, -1, -1, 0);
      run_xfer(0, 2'd1, 8'($urandom), 8'($urandom), 100, -1, 0);
      run_xfer(0, 2'd3, 8'($urandom), 8'($urandom), 200, -1, 0);
      run_xfer(0, 2'd0, 8'($urandom), 8'($urandom), 0, -1, 0);

      // Reset pulse with bit_cnt=5 in mode 0, then recovery.
      run_xfer(0, 2'd0, 8'($urandom), 8'($urandom), -1, 8, 0);
      run_xfer(0, 2'd0, 8'hA5, 8'h3C, -1, -1, 0);

      // Start spam and mode toggling while busy.
      for (int m = 0; m < 4; m++) run_xfer(0, 2'(m), 8'($urandom), 8'($urandom), -1, -1, 1);

      // Setup/hold parameter sweep on the other instances.
      for (int d = 1; d < NI; d++) begin
         for (int m = 0; m < 4; m++) run_xfer(d, 2'(m), 8'hA5, 8'h3C, -1, -1, 0);
         run_xfer(d, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 200, -1, 1);
      end

      for (int i = 0; i < 24; i++) begin
         dd  = int'($urandom_range(0, NI - 1));
         sel = int'($urandom_range(0, 3));
         run_xfer(dd, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  (sel == 0) ? int'($urandom_range(0, 2*N - 1)) : -1, -1, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
